// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one single-port memory between instruction fetch and data.
// Only one transaction is outstanding at a time. Data wins by default; after four back-to-back data grants, a waiting fetch wins.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    D_XFER  = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  state_t     state;
  state_t     state_next;
  logic [2:0] starve_cnt;
  logic [2:0] starve_next;
  logic       arb_en;
  logic       complete;
  logic       pick_fetch;
  logic       pick_data;

  // Arbitration happens in IDLE or on the edge that completes the current transfer.
  // mem_ready is meaningless in IDLE, so it can only complete a transfer while one is active.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_next  = state;
    starve_next = starve_cnt;
    complete    = (state != IDLE) && mem_ready;
    arb_en      = (state == IDLE) || mem_ready;
    pick_fetch  = arb_en && if_req && (!d_req || (starve_cnt == STARVE_LIMIT));
    pick_data   = arb_en && d_req && !pick_fetch;

    if (arb_en) begin
      if (pick_fetch)     state_next = IF_XFER;
      else if (pick_data) state_next = D_XFER;
      else                state_next = IDLE;
    end

    if (!if_req || pick_fetch)
      starve_next = '0;
    else if (pick_data && (starve_cnt != STARVE_LIMIT))
      starve_next = starve_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every flop samples values from before the edge.
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Every output is registered. gnt pulses in the first XFER cycle; rvalid pulses the cycle after mem_ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= pick_fetch;
      d_gnt     <= pick_data;
      if_rvalid <= complete && (state == IF_XFER);
      d_rvalid  <= complete && (state == D_XFER);

      if (complete && (state == IF_XFER)) if_rdata <= mem_rdata;
      if (complete && (state == D_XFER))  d_rdata  <= mem_rdata;

      if (pick_fetch) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= 4'hF;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else if (pick_data) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (arb_en) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_be    <= '0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic.
// A transaction-level reference model supplies every expected output.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
  } outs_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  outs_t exp_o;
  int    owner;            // 0 = nobody, 1 = fetch, 2 = data
  int    starve;
  int    grant_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: decides which transaction owns the memory after each clock edge.
  task automatic model_step();
    int winner;
    winner = 0;
    if (!reset_n) begin
      exp_o  = '0;
      owner  = 0;
      starve = 0;
      return;
    end
    exp_o.if_gnt    = 1'b0;
    exp_o.d_gnt     = 1'b0;
    exp_o.if_rvalid = (owner == 1) && mem_ready;
    exp_o.d_rvalid  = (owner == 2) && mem_ready;
    if (exp_o.if_rvalid) exp_o.if_rdata = mem_rdata;
    if (exp_o.d_rvalid)  exp_o.d_rdata  = mem_rdata;
    if (owner == 0 || mem_ready) begin
      if (if_req && (starve >= 4 || !d_req)) winner = 1;
      else if (d_req)                        winner = 2;
      owner = winner;
      case (winner)
        1: begin
          exp_o.if_gnt = 1'b1;
          exp_o.mem_req = 1'b1; exp_o.mem_we = 1'b0; exp_o.mem_be = 4'hF;
          exp_o.mem_addr = if_addr; exp_o.mem_wdata = 32'h0;
        end
        2: begin
          exp_o.d_gnt = 1'b1;
          exp_o.mem_req = 1'b1; exp_o.mem_we = d_we; exp_o.mem_be = d_be;
          exp_o.mem_addr = d_addr; exp_o.mem_wdata = d_wdata;
        end
        default: exp_o.mem_req = 1'b0;
      endcase
      if (winner != 0) grant_log.push_back(winner);
    end
    if (!if_req || winner == 1) starve = 0;
    else if (winner == 2)       starve = (starve >= 4) ? 4 : starve + 1;
  endtask

  task automatic compare_all();
    check("pulses", {60'h0, if_gnt, if_rvalid, d_gnt, d_rvalid},
          {60'h0, exp_o.if_gnt, exp_o.if_rvalid, exp_o.d_gnt, exp_o.d_rvalid});
    check("mem_req", {63'h0, mem_req}, {63'h0, exp_o.mem_req});
    if (exp_o.mem_req) begin
      check("mem_ctl", {59'h0, mem_we, mem_be}, {59'h0, exp_o.mem_we, exp_o.mem_be});
      check("mem_addr", {32'h0, mem_addr}, {32'h0, exp_o.mem_addr});
      check("mem_wdata", {32'h0, mem_wdata}, {32'h0, exp_o.mem_wdata});
    end
    if (exp_o.if_rvalid) check("if_rdata", {32'h0, if_rdata}, {32'h0, exp_o.if_rdata});
    if (exp_o.d_rvalid)  check("d_rdata", {32'h0, d_rdata}, {32'h0, exp_o.d_rdata});
  endtask

  // Inputs are changed at the negedge; the model steps on the same edge that the DUT samples.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {54'h0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, mem_be}, 64'h0);
    check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'h0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'h0);
  endtask

  task automatic drive_random();
    if (exp_o.if_gnt) if_req = 1'b0;
    if (exp_o.d_gnt)  d_req  = 1'b0;
    if (!if_req) begin
      if ($urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      if_req = 1'b0;
    end
    if (!d_req) begin
      if ($urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      d_req = 1'b0;
    end
    mem_ready = ($urandom_range(0, 2) == 0);
    mem_rdata = $urandom;
    reset_n   = ($urandom_range(0, 149) != 0);
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    owner = 0; starve = 0; exp_o = '0;
    @(negedge clk);
    cycle(); cycle();
    check_all_zero("reset");
    reset_n = 1'b1;

    // Fetch only, two wait states.
    if_req = 1'b1; if_addr = 32'h100;
    cycle();
    check("fetch_gnt", {63'h0, if_gnt}, 64'h1);
    check("fetch_addr", {32'h0, mem_addr}, 64'h100);
    if_req = 1'b0;
    cycle(); cycle();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    cycle();
    mem_ready = 1'b0;
    check("fetch_rvalid", {32'h0, if_rvalid, d_rvalid, 30'h0}, {32'h0, 2'b10, 30'h0});
    check("fetch_rdata", {32'h0, if_rdata}, 64'h13);

    // Simultaneous fetch and load with immediate completion.
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000; mem_ready = 1'b1;
    cycle();
    check("sim_first", {62'h0, if_gnt, d_gnt}, 64'h1);
    check("sim_daddr", {32'h0, mem_addr}, 64'h2000);
    d_req = 1'b0;
    cycle();
    check("sim_second", {60'h0, if_gnt, d_gnt, d_rvalid, mem_req}, 64'hB);
    check("sim_faddr", {32'h0, mem_addr}, 64'h400);
    if_req = 1'b0;
    cycle();
    check("sim_done", {62'h0, if_rvalid, mem_req}, 64'h2);
    mem_ready = 1'b0;

    // Store held through wait states.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h3004; d_wdata = 32'hDEAD_BEEF;
    cycle();
    check("st_gnt", {63'h0, d_gnt}, 64'h1);
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("st_ctl", {58'h0, mem_req, mem_we, mem_be}, {58'h0, 6'b11_0011});
      check("st_addr", {mem_addr, mem_wdata}, {32'h3004, 32'hDEAD_BEEF});
    end
    mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    check("st_ack", {62'h0, d_rvalid, mem_req}, 64'h2);

    // Starvation: both requesters always pending.
    grant_log.delete();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; mem_ready = 1'b1;
    repeat (20) cycle();
    if_req = 1'b0; d_req = 1'b0;
    cycle();
    mem_ready = 1'b0;
    cycle();
    check("starve_count", 64'(grant_log.size()), 64'd20);
    for (int i = 0; i < grant_log.size(); i++)
      check("starve_pattern", 64'(grant_log[i]), (i % 5 == 4) ? 64'd1 : 64'd2);

    // Reset during a data transfer wait, then a late mem_ready.
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h5000;
    cycle();
    d_req = 1'b0;
    cycle();
    reset_n = 1'b0;
    cycle();
    check_all_zero("rst_mid");
    reset_n = 1'b1; mem_ready = 1'b1;
    cycle();
    check("rst_late", {62'h0, d_rvalid, mem_req}, 64'h0);
    mem_ready = 1'b0;
    cycle();
    check("rst_late2", {63'h0, d_rvalid}, 64'h0);

    // Back-to-back fetches, one completion per cycle.
    if_req = 1'b1; if_addr = 32'h800; mem_ready = 1'b1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      if_addr = if_addr + 32'd4;
      cycle();
      check("b2b", {61'h0, mem_req, if_gnt, if_rvalid}, 64'h7);
    end
    if_req = 1'b0;
    cycle();
    mem_ready = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
